// File: rtl/cordic_pkg.sv
// Shared types and helpers for the sequential CORDIC engine: state encoding,
// default widths and the sign-magnitude zero normaliser.
package cordic_pkg;

  localparam int CORDIC_W  = 16;
  localparam int ATAN_FRAC = CORDIC_W - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_XU,
    S_YU,
    S_ZU,
    S_DONE
  } state_t;

  // A zero magnitude is always stored as +0 so sign tests never see -0.
  function automatic logic sm_norm_sign(input logic sign, input logic mag_is_zero);
    return sign & ~mag_is_zero;
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent table: idx -> round(atan(2^-idx) * 2^FRAC).
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int W    = CORDIC_W,
  parameter int FRAC = ATAN_FRAC,
  parameter int IW   = 4
) (
  input  logic [IW-1:0] idx,
  output logic [W-1:0]  atan
);

  localparam int          SHIFT = 30 - FRAC;
  localparam logic [32:0] HALF  = (33'd1 << SHIFT) >> 1;

  // Entries are floor(atan(2^-k) * 2^30); flooring first keeps the final
  // round-half-up exact, since the true value lies within one unit above.
  function automatic logic [31:0] atan_q30(input int k);
    logic [31:0] v;
    case (k)
      0:       v = 32'd843314856;
      1:       v = 32'd497837829;
      2:       v = 32'd263043836;
      3:       v = 32'd133525158;
      4:       v = 32'd67021686;
      5:       v = 32'd33543515;
      6:       v = 32'd16775850;
      7:       v = 32'd8388437;
      8:       v = 32'd4194282;
      9:       v = 32'd2097149;
      default: v = (k <= 30) ? ((32'h4000_0000 >> k) - 32'd1) : 32'd0;
    endcase
    return v;
  endfunction

  assign atan = W'(({1'b0, atan_q30(int'(idx))} + HALF) >> SHIFT);

endmodule

// File: rtl/cordic_seq.sv
// Iterative CORDIC sequencer sharing one external sign-magnitude adder across
// the X, Y and Z updates. Define CORDIC_VECTORING_EN to add the vectoring mode.
module cordic_seq
  import cordic_pkg::*;
#(
  parameter int W      = CORDIC_W,
  parameter int N_ITER = 16
) (
  input  logic         clk,
  input  logic         reset,
`ifdef CORDIC_VECTORING_EN
  input  logic         mode,
`endif
  input  logic         start,
  input  logic         x0_sign,
  input  logic         y0_sign,
  input  logic         z0_sign,
  input  logic [W-1:0] x0,
  input  logic [W-1:0] y0,
  input  logic [W-1:0] z0,
  output logic         busy,
  output logic         done,
  output logic         x_sign,
  output logic         y_sign,
  output logic         z_sign,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic [W-1:0] z,
  output logic [W-1:0] add_a,
  output logic         add_asign,
  output logic [W-1:0] add_b,
  output logic         add_as,
  input  logic [W-1:0] add_s,
  input  logic         add_sign
);

  localparam int            IW     = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(N_ITER - 1);

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] iter;
  logic          dir;
  logic          dir_start;
  logic          dir_next;
  logic [W-1:0]  x_nxt;
  logic          x_nxt_sign;
  logic [W-1:0]  atan_val;
  logic          res_sign;

  cordic_atan_rom #(
    .W   (W),
    .FRAC(W - 2),
    .IW  (IW)
  ) u_atan (
    .idx (iter),
    .atan(atan_val)
  );

  assign res_sign = sm_norm_sign(add_sign, add_s == '0);

  // dir = 1 rotates counter-clockwise (subtract y from x, subtract angle from z).
`ifdef CORDIC_VECTORING_EN
  logic vec;

  assign dir_start = mode ? y0_sign : ~z0_sign;
  assign dir_next  = vec ? y_sign : ~res_sign;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec <= 1'b0;
    end else if (state == S_IDLE && start) begin
      vec <= mode;
    end
  end
`else
  assign dir_start = ~z0_sign;
  assign dir_next  = ~res_sign;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    add_a     = '0;
    add_asign = 1'b0;
    add_b     = '0;
    add_as    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_XU;
        end
      end
      S_XU: begin
        add_a     = x;
        add_asign = x_sign;
        add_b     = y >> iter;
        add_as    = dir ^ y_sign;
        state_nxt = S_YU;
      end
      // x is still the pre-rotation value here; its update sits in x_nxt.
      S_YU: begin
        add_a     = y;
        add_asign = y_sign;
        add_b     = x >> iter;
        add_as    = ~dir ^ x_sign;
        state_nxt = S_ZU;
      end
      S_ZU: begin
        add_a     = z;
        add_asign = z_sign;
        add_b     = atan_val;
        add_as    = dir;
        state_nxt = (iter == I_LAST) ? S_DONE : S_XU;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy = (state == S_XU) || (state == S_YU) || (state == S_ZU);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iter       <= '0;
      dir        <= 1'b0;
      x          <= '0;
      y          <= '0;
      z          <= '0;
      x_sign     <= 1'b0;
      y_sign     <= 1'b0;
      z_sign     <= 1'b0;
      x_nxt      <= '0;
      x_nxt_sign <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            x      <= x0;
            y      <= y0;
            z      <= z0;
            x_sign <= x0_sign;
            y_sign <= y0_sign;
            z_sign <= z0_sign;
            iter   <= '0;
            dir    <= dir_start;
          end
        end
        S_XU: begin
          x_nxt      <= add_s;
          x_nxt_sign <= res_sign;
        end
        S_YU: begin
          y      <= add_s;
          y_sign <= res_sign;
          x      <= x_nxt;
          x_sign <= x_nxt_sign;
        end
        S_ZU: begin
          z      <= add_s;
          z_sign <= res_sign;
          if (iter != I_LAST) begin
            iter <= iter + 1'b1;
            dir  <= dir_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
